parking_allocator: RTL and testbench

PARKING_ALLOCATOR -- requirements
Module: parking_allocator

---
 rtl/parking_pkg.sv | 31 +++
 rtl/parking_allocator_resv_timer.sv | 37 +++
 rtl/parking_allocator.sv | 124 ++++++++++++
 tb/tb_parking_allocator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking allocator: slot geometry, gate FSM
// states and small bit-vector helpers used by the top level.
package parking_pkg;

  localparam int NUM_SLOTS = 6;
  localparam int SLOT_W    = 3;
  localparam int COUNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    EXIT  = 2'd2,
    DENY  = 2'd3
  } gate_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [SLOT_W-1:0] lowest_slot(input logic [NUM_SLOTS-1:0] v);
    lowest_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (v[i]) lowest_slot = SLOT_W'(i);
    end
  endfunction

  function automatic logic [COUNT_W-1:0] popcount(input logic [NUM_SLOTS-1:0] v);
    popcount = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      popcount = popcount + COUNT_W'(v[i]);
    end
  endfunction

endpackage

// File: rtl/parking_allocator_resv_timer.sv
// Per-slot reservation timer: expire is asserted during the last of
// RESV_CYCLES cycles following start, unless clear cancels it first.
module resv_timer #(
  parameter int RESV_CYCLES = 1_000_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expire
);

  localparam int CW = (RESV_CYCLES > 1) ? $clog2(RESV_CYCLES + 1) : 1;

  logic [CW-1:0] cnt;
  logic          active;

  assign expire = active && (cnt == CW'(RESV_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      active <= 1'b1;
    end else if (clear || expire) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (active) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/parking_allocator.sv
// Parking lot allocator: tracks slot occupancy, reserves the lowest free slot
// for each admitted car, drives the entry/exit gate and reports park/leave events.
module parking_allocator
  import parking_pkg::*;
#(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int RESV_CYCLES = 1_000_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SLOTS-1:0] status,
  input  logic                 entry_req,
  input  logic                 exit_req,
  output logic                 gate_open,
  output logic                 assign_valid,
  output logic [SLOT_W-1:0]    assign_slot,
  output logic                 deny,
  output logic [COUNT_W-1:0]   avail_count,
  output logic                 full,
  output logic [NUM_SLOTS-1:0] park_evt,
  output logic [NUM_SLOTS-1:0] leave_evt
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  logic [NUM_SLOTS-1:0] status_q, status_qq;
  logic                 primed;
  logic [NUM_SLOTS-1:0] reserved, avail, rise, fall, expire, grant_vec;
  logic [SLOT_W-1:0]    grant_slot;
  logic [COUNT_W-1:0]   avail_pop;

  gate_state_e          state, state_next;
  logic [GW-1:0]        gate_cnt, gate_cnt_next;
  logic                 grant, deny_now;

  assign rise       = status_q & ~status_qq;
  assign fall       = ~status_q & status_qq;
  assign avail      = ~status_q & ~reserved;
  assign avail_pop  = popcount(avail);
  assign grant_slot = lowest_slot(avail);
  assign grant_vec  = grant ? (NUM_SLOTS'(1) << grant_slot) : '0;
  assign gate_open  = (state == ENTRY) || (state == EXIT);

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_resv
    resv_timer #(.RESV_CYCLES(RESV_CYCLES)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .start (grant_vec[i]),
      .clear (rise[i]),
      .expire(expire[i])
    );
  end

  // NOTE: every variable written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    gate_cnt_next = gate_cnt;
    grant         = 1'b0;
    deny_now      = 1'b0;
    case (state)
      IDLE: begin
        if (exit_req) begin
          state_next    = EXIT;
          gate_cnt_next = GW'(GATE_CYCLES - 1);
        end else if (entry_req) begin
          // full is one cycle stale; an empty avail vector also refuses entry
          if (!full && (|avail)) begin
            state_next    = ENTRY;
            gate_cnt_next = GW'(GATE_CYCLES - 1);
            grant         = 1'b1;
          end else begin
            state_next = DENY;
            deny_now   = 1'b1;
          end
        end
      end
      ENTRY, EXIT: begin
        if (gate_cnt == '0) state_next = IDLE;
        else                gate_cnt_next = gate_cnt - GW'(1);
      end
      DENY: begin
        if (!entry_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: reset is synchronous; every register here, including the
  // reservation bits, is returned to a known value when rst is sampled high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      gate_cnt     <= '0;
      status_q     <= '0;
      status_qq    <= '0;
      primed       <= 1'b0;
      reserved     <= '0;
      assign_valid <= 1'b0;
      assign_slot  <= '0;
      deny         <= 1'b0;
      avail_count  <= COUNT_W'(NUM_SLOTS);
      full         <= 1'b0;
      park_evt     <= '0;
      leave_evt    <= '0;
    end else begin
      state        <= state_next;
      gate_cnt     <= gate_cnt_next;
      status_q     <= status;
      // First cycle out of reset seeds both stages so occupied slots raise no events
      status_qq    <= primed ? status_q : status;
      primed       <= 1'b1;
      reserved     <= (reserved & ~(rise | expire)) | grant_vec;
      assign_valid <= grant;
      if (grant) assign_slot <= grant_slot;
      deny         <= deny_now;
      avail_count  <= avail_pop;
      full         <= (avail_pop == '0);
      park_evt     <= rise;
      leave_evt    <= fall;
    end
  end

endmodule

// File: tb/tb_parking_allocator.sv
// Randomized bench for parking_allocator with a behavioural reference model
// that tracks reservations as remaining-time counters and the gate as open time left.
module tb_parking_allocator;

  localparam int GATE = 4;
  localparam int RESV = 20;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_EXIT = 2, M_DENY = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] status = '0;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic       gate_open, assign_valid, deny, full;
  logic [2:0] assign_slot, avail_count;
  logic [5:0] park_evt, leave_evt;

  parking_allocator #(.GATE_CYCLES(GATE), .RESV_CYCLES(RESV)) dut (
    .clk         (clk),
    .rst         (rst),
    .status      (status),
    .entry_req   (entry_req),
    .exit_req    (exit_req),
    .gate_open   (gate_open),
    .assign_valid(assign_valid),
    .assign_slot (assign_slot),
    .deny        (deny),
    .avail_count (avail_count),
    .full        (full),
    .park_evt    (park_evt),
    .leave_evt   (leave_evt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit [5:0] m_sq, m_sqq;
  bit       m_primed;
  int       m_left [6];
  int       m_mode;
  int       m_gate_left;
  int       m_count;
  bit       m_full, m_av, m_deny;
  int       m_slot;
  bit [5:0] m_park, m_leave;

  int cnt_gate, cnt_deny, cnt_valid, cnt_leave5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sq = '0; m_sqq = '0; m_primed = 0;
    foreach (m_left[i]) m_left[i] = 0;
    m_mode = M_IDLE; m_gate_left = 0;
    m_count = 6; m_full = 0;
    m_av = 0; m_deny = 0; m_slot = 0;
    m_park = '0; m_leave = '0;
  endtask

  task automatic model_edge();
    bit [5:0] rise, fall;
    int n, k;
    if (rst) begin
      model_reset();
    end else begin
      rise = m_sq & ~m_sqq;
      fall = ~m_sq & m_sqq;
      n = 0;
      k = -1;
      for (int i = 0; i < 6; i++) begin
        if (!m_sq[i] && m_left[i] == 0) begin
          n++;
          if (k < 0) k = i;
        end
      end
      m_park = rise; m_leave = fall;
      m_av = 0; m_deny = 0;
      for (int i = 0; i < 6; i++)
        if (m_left[i] > 0) m_left[i] = rise[i] ? 0 : m_left[i] - 1;
      case (m_mode)
        M_IDLE: begin
          if (exit_req) begin
            m_mode = M_EXIT; m_gate_left = GATE;
          end else if (entry_req) begin
            if (!m_full && n > 0) begin
              m_mode = M_ENTRY; m_gate_left = GATE;
              m_left[k] = RESV; m_av = 1; m_slot = k;
            end else begin
              m_mode = M_DENY; m_deny = 1;
            end
          end
        end
        M_ENTRY, M_EXIT: begin
          m_gate_left--;
          if (m_gate_left == 0) m_mode = M_IDLE;
        end
        default: if (!entry_req) m_mode = M_IDLE;
      endcase
      m_count = n;
      m_full = (n == 0);
      m_sqq = m_primed ? m_sq : status;
      m_sq = status;
      m_primed = 1;
    end
  endtask

  task automatic compare();
    check("gate_open", gate_open, (m_mode == M_ENTRY || m_mode == M_EXIT));
    check("assign_valid", assign_valid, m_av);
    if (m_av) check("assign_slot", assign_slot, m_slot);
    check("deny", deny, m_deny);
    check("avail_count", avail_count, m_count);
    check("full", full, m_full);
    check("park_evt", park_evt, m_park);
    check("leave_evt", leave_evt, m_leave);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    if (gate_open) cnt_gate++;
    if (deny) cnt_deny++;
    if (assign_valid) cnt_valid++;
    if (leave_evt[5]) cnt_leave5++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_counts();
    cnt_gate = 0; cnt_deny = 0; cnt_valid = 0; cnt_leave5 = 0;
  endtask

  task automatic do_reset(input logic [5:0] st);
    status = st; entry_req = 0; exit_req = 0;
    rst = 1; run(2);
    check("rst_avail", avail_count, 6);
    check("rst_gate", gate_open, 0);
    check("rst_full", full, 0);
    rst = 0; run(3);
  endtask

  initial begin
    model_reset();
    clear_counts();
    #2;

    // Empty lot, single entry pulse
    do_reset(6'b000000);
    clear_counts();
    entry_req = 1; step(); entry_req = 0; run(9);
    check("s1_gate_cycles", cnt_gate, GATE);
    check("s1_valid", cnt_valid, 1);
    check("s1_count", avail_count, 5);

    // One free slot: grant, then a held request is denied exactly once
    do_reset(6'b111110);
    entry_req = 1; step(); entry_req = 0; run(8);
    check("s2_full", full, 1);
    clear_counts();
    entry_req = 1; run(6); entry_req = 0; run(3);
    check("s2_deny_once", cnt_deny, 1);
    check("s2_gate_closed", cnt_gate, 0);

    // Simultaneous entry and exit: exit first, then entry after one idle cycle
    do_reset(6'b000000);
    clear_counts();
    entry_req = 1; exit_req = 1; step(); exit_req = 0; run(5); entry_req = 0; run(6);
    check("s3_gate_cycles", cnt_gate, 2 * GATE);
    check("s3_valid", cnt_valid, 1);

    // Reservation of slot 2 expiring, then parked into at cycle 5
    do_reset(6'b000011);
    entry_req = 1; step(); entry_req = 0; run(RESV + 4);
    check("s4_restored", avail_count, 4);
    entry_req = 1; step(); entry_req = 0; run(4);
    status = 6'b000111; run(4);
    check("s4_after_park", avail_count, 3);

    // Reset in the middle of the second entry with two reservations held
    do_reset(6'b000001);
    entry_req = 1; step(); entry_req = 0; run(6);
    entry_req = 1; step(); entry_req = 0; run(1);
    rst = 1; step();
    check("s5_gate_closed", gate_open, 0);
    check("s5_avail", avail_count, 6);
    rst = 0; run(3);
    check("s5_avail_settled", avail_count, 5);

    // Slot 5 vacated
    do_reset(6'b100000);
    clear_counts();
    status = 6'b000000; run(6);
    check("s6_leave_once", cnt_leave5, 1);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) entry_req = ~entry_req;
      if ($urandom_range(0, 19) == 0) exit_req = ~exit_req;
      if ($urandom_range(0, 9) == 0) status[$urandom_range(0, 5)] ^= 1'b1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
